// File: rtl/clkdiv_pkg.sv
// -----------------------------------------------------------------------------
// clkdiv_pkg
// Shared definitions for the multi-channel clock divider.
//   DEF_CNT_W    : default width of the half-period value and per-channel counter
//   DEF_RST_HALF : half-period loaded into every channel at reset (50 MHz -> 1 MHz)
//   ch_w()       : width of the channel-select field, never less than 1
//   chan_flags_t : single-bit state held by each channel
// Optional feature macro used by the files that import this package:
//   CLKDIV_TICK_EN - adds the per-channel tick output.
// -----------------------------------------------------------------------------
package clkdiv_pkg;

    localparam int DEF_CNT_W    = 16;
    localparam int DEF_RST_HALF = 25;

    // A single channel still needs a 1-bit select so the port exists.
    function automatic int ch_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    // Per-channel flag state. The counter and the two half-period values are
    // kept as separate CNT_W-wide registers inside the channel because their
    // width is a module parameter.
    typedef struct packed {
        logic pend_valid;  // a written half-period waits to be applied
        logic out;         // divided square-wave level
    } chan_flags_t;

endpackage

// File: rtl/clkdiv_chan.sv
// -----------------------------------------------------------------------------
// clkdiv_chan
// One divider channel: counter, current/pending half-period, output level and
// (with CLKDIV_TICK_EN defined) a one-cycle pulse on every rising toggle.
// Ports:
//   clk_i   - system clock
//   rst_i   - synchronous, active-high reset
//   en_i    - run enable; low forces the output low and the counter to 0
//   we_i    - write strobe for half_i (already decoded for this channel)
//   half_i  - new half-period in clk cycles (0 is treated as 1)
//   out_o   - registered divided output
//   pend_o  - registered: a written value waits to be applied
//   tick_o  - registered rising-toggle pulse (CLKDIV_TICK_EN only)
// -----------------------------------------------------------------------------
module clkdiv_chan
    import clkdiv_pkg::*;
#(
    parameter int CNT_W    = DEF_CNT_W,
    parameter int RST_HALF = DEF_RST_HALF
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             we_i,
    input  logic [CNT_W-1:0] half_i,
`ifdef CLKDIV_TICK_EN
    output logic             tick_o,
`endif
    output logic             out_o,
    output logic             pend_o
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HALF_RST = CNT_W'(RST_HALF);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_cur_q, half_cur_d;
    logic [CNT_W-1:0] half_pend_q, half_pend_d;
    chan_flags_t      flags_q, flags_d;
    logic             wrap;

    // half_cur is never 0 (reset value and writes are clamped), so the
    // subtraction cannot underflow and the counter tops out at half_cur-1.
    assign wrap = (cnt_q == (half_cur_q - ONE));

    always_comb begin
        cnt_d       = cnt_q;
        half_cur_d  = half_cur_q;
        half_pend_d = half_pend_q;
        flags_d     = flags_q;

        if (!en_i) begin
            // Idle: park low and take any waiting value straight away.
            cnt_d       = '0;
            flags_d.out = 1'b0;
            if (flags_q.pend_valid) begin
                half_cur_d         = half_pend_q;
                flags_d.pend_valid = 1'b0;
            end
        end else if (wrap) begin
            cnt_d       = '0;
            flags_d.out = ~flags_q.out;
            if (flags_q.pend_valid) begin
                half_cur_d         = half_pend_q;
                flags_d.pend_valid = 1'b0;
            end
        end else begin
            cnt_d = cnt_q + ONE;
        end

        // A write lands after the wrap/disable decision above, so a write in
        // the same cycle stays pending for the next application point.
        if (we_i) begin
            half_pend_d        = (half_i == '0) ? ONE : half_i;
            flags_d.pend_valid = 1'b1;
        end
    end

`ifdef CLKDIV_TICK_EN
    logic tick_q, tick_d;
    // High during the first cycle the output is high after a rising toggle.
    assign tick_d = en_i & wrap & ~flags_q.out;
    assign tick_o = tick_q;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            half_cur_q  <= HALF_RST;
            half_pend_q <= HALF_RST;
            flags_q     <= '0;
`ifdef CLKDIV_TICK_EN
            tick_q      <= 1'b0;
`endif
        end else begin
            cnt_q       <= cnt_d;
            half_cur_q  <= half_cur_d;
            half_pend_q <= half_pend_d;
            flags_q     <= flags_d;
`ifdef CLKDIV_TICK_EN
            tick_q      <= tick_d;
`endif
        end
    end

    assign out_o  = flags_q.out;
    assign pend_o = flags_q.pend_valid;

endmodule

// File: rtl/clkdiv_multi.sv
// -----------------------------------------------------------------------------
// clkdiv_multi
// NUM_CH independent programmable square-wave dividers off one system clock.
// A half-period written at runtime takes effect at the channel's next toggle
// (or immediately while the channel is disabled), so outputs never glitch.
// Ports:
//   clk      - system clock
//   rst      - synchronous, active-high reset
//   ch_en    - per-channel run enable
//   cfg_we   - one-cycle write strobe
//   cfg_ch   - target channel; indices >= NUM_CH are ignored
//   cfg_half - new half-period in clk cycles (0 clamps to 1)
//   clk_out  - registered divided output per channel
//   pend     - registered: a written value is waiting on this channel
//   tick     - registered one-cycle pulse per rising toggle
//              (present only when CLKDIV_TICK_EN is defined)
// -----------------------------------------------------------------------------
module clkdiv_multi
    import clkdiv_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = DEF_CNT_W,
    parameter int RST_HALF = DEF_RST_HALF,
    localparam int CH_W    = ch_w(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_we,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_half,
`ifdef CLKDIV_TICK_EN
    output logic [NUM_CH-1:0] tick,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] pend
);

    logic [NUM_CH-1:0] ch_we;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        // Out-of-range indices match no channel, so such writes are dropped.
        assign ch_we[i] = cfg_we & (cfg_ch == CH_W'(i));

        clkdiv_chan #(
            .CNT_W    (CNT_W),
            .RST_HALF (RST_HALF)
        ) u_chan (
            .clk_i  (clk),
            .rst_i  (rst),
            .en_i   (ch_en[i]),
            .we_i   (ch_we[i]),
            .half_i (cfg_half),
`ifdef CLKDIV_TICK_EN
            .tick_o (tick[i]),
`endif
            .out_o  (clk_out[i]),
            .pend_o (pend[i])
        );
    end

endmodule

// File: tb/tb_clkdiv_multi.sv
// -----------------------------------------------------------------------------
// tb_clkdiv_multi
// Bench for clkdiv_multi with NUM_CH=3 (so cfg_ch=3 is out of range).
// A schedule-based model tracks, per channel, the absolute edge number of the
// next toggle; outputs are compared against it on every falling edge. Directed
// scenarios additionally measure toggle spacing against hand-computed numbers.
// -----------------------------------------------------------------------------
module tb_clkdiv_multi;

    localparam int NUM_CH   = 3;
    localparam int CNT_W    = 16;
    localparam int RST_HALF = 25;
    localparam int CH_W     = 2;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              cfg_we;
    logic [CH_W-1:0]   cfg_ch;
    logic [CNT_W-1:0]  cfg_half;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] pend;
`ifdef CLKDIV_TICK_EN
    logic [NUM_CH-1:0] tick;
`endif

    int checks   = 0;
    int failures = 0;
    logic cmp_on = 1'b0;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    clkdiv_multi #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .RST_HALF (RST_HALF)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ch_en    (ch_en),
        .cfg_we   (cfg_we),
        .cfg_ch   (cfg_ch),
        .cfg_half (cfg_half),
`ifdef CLKDIV_TICK_EN
        .tick     (tick),
`endif
        .clk_out  (clk_out),
        .pend     (pend)
    );

    // ---------------- model ----------------
    int                edge_n = 0;
    logic [NUM_CH-1:0] m_out  = '0;
    logic [NUM_CH-1:0] m_pend = '0;
    logic [NUM_CH-1:0] m_tick = '0;
    logic [NUM_CH-1:0] m_run  = '0;
    int                m_half  [NUM_CH];
    int                m_hpend [NUM_CH];
    int                m_next  [NUM_CH];

    always @(posedge clk) begin
        edge_n++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (rst) begin
                m_out[i]   = 1'b0;
                m_pend[i]  = 1'b0;
                m_tick[i]  = 1'b0;
                m_run[i]   = 1'b0;
                m_half[i]  = RST_HALF;
                m_hpend[i] = RST_HALF;
                m_next[i]  = 0;
            end else begin
                m_tick[i] = 1'b0;
                if (!ch_en[i]) begin
                    m_out[i] = 1'b0;
                    m_run[i] = 1'b0;
                    if (m_pend[i]) begin
                        m_half[i] = m_hpend[i];
                        m_pend[i] = 1'b0;
                    end
                end else begin
                    // First enabled edge counts as edge 1 of the first half.
                    if (!m_run[i]) begin
                        m_run[i]  = 1'b1;
                        m_next[i] = edge_n + m_half[i] - 1;
                    end
                    if (edge_n == m_next[i]) begin
                        m_out[i]  = ~m_out[i];
                        m_tick[i] = m_out[i];
                        if (m_pend[i]) begin
                            m_half[i] = m_hpend[i];
                            m_pend[i] = 1'b0;
                        end
                        m_next[i] = edge_n + m_half[i];
                    end
                end
                if (cfg_we && int'(cfg_ch) == i) begin
                    m_hpend[i] = (cfg_half == '0) ? 1 : int'(cfg_half);
                    m_pend[i]  = 1'b1;
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        if (cmp_on) begin
            checks++;
            if (clk_out !== m_out) begin
                failures++;
                $display("FAIL clk_out @%0t: got %b expected %b", $time, clk_out, m_out);
            end
            checks++;
            if (pend !== m_pend) begin
                failures++;
                $display("FAIL pend @%0t: got %b expected %b", $time, pend, m_pend);
            end
`ifdef CLKDIV_TICK_EN
            checks++;
            if (tick !== m_tick) begin
                failures++;
                $display("FAIL tick @%0t: got %b expected %b", $time, tick, m_tick);
            end
`endif
        end
    end

    // ---------------- driver / literal-check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until clk_out[ch] changes level; bounded at 200 edges.
    task automatic wait_change(input int ch, input string name, input int exp);
        logic prev;
        int   n;
        prev = clk_out[ch];
        n = 0;
        do begin
            step();
            n++;
        end while (clk_out[ch] === prev && n < 200);
        check(name, n, exp);
    endtask

    task automatic cfg_write(input int ch, input int half);
        cfg_we   = 1'b1;
        cfg_ch   = CH_W'(ch);
        cfg_half = CNT_W'(half);
        step();
        cfg_we   = 1'b0;
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        rst      = 1'b1;
        ch_en    = '0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_half = '0;
        step();
        step();
        rst    = 1'b0;
        cmp_on = 1'b1;
        check("reset_clk_out", 32'(clk_out), 0);
        check("reset_pend", 32'(pend), 0);

        // Default half of 25 on ch0.
        ch_en = 3'b001;
        wait_change(0, "ch0_first_rise", 25);
        wait_change(0, "ch0_high_time", 25);
        wait_change(0, "ch0_low_time", 25);
        check("ch1_ch2_idle", 32'(clk_out[2:1]), 0);

        // Write half=3 ten edges into a 25-cycle half.
        repeat (10) step();
        cfg_write(0, 3);
        check("ch0_pend_set", 32'(pend[0]), 1);
        wait_change(0, "ch0_finish_old_half", 14);
        check("ch0_pend_clear", 32'(pend[0]), 0);
        wait_change(0, "ch0_half3_a", 3);
        wait_change(0, "ch0_half3_b", 3);

        // Write landing exactly on a wrap edge: old half runs once more.
        step();
        step();
        cfg_write(0, 7);
        check("ch0_wrap_write_pend", 32'(pend[0]), 1);
        wait_change(0, "ch0_wrap_write_old", 3);
        check("ch0_wrap_write_applied", 32'(pend[0]), 0);
        wait_change(0, "ch0_half7", 7);

        // Back-to-back writes: last one wins.
        cfg_write(0, 4);
        cfg_write(0, 2);
        wait_change(0, "ch0_rest_of_half7", 5);
        wait_change(0, "ch0_last_write_wins", 2);

        // ch2: disable mid-count, write while idle, re-enable.
        ch_en = 3'b101;
        wait_change(2, "ch2_first_rise", 25);
        repeat (5) step();
        ch_en = 3'b001;
        step();
        check("ch2_disabled_low", 32'(clk_out[2]), 0);
        cfg_write(2, 5);
        check("ch2_pend_set", 32'(pend[2]), 1);
        step();
        check("ch2_pend_applied_idle", 32'(pend[2]), 0);
        ch_en = 3'b101;
        wait_change(2, "ch2_rise_half5", 5);
        wait_change(2, "ch2_fall_half5", 5);

        // ch1: half 0 clamps to 1.
        cfg_write(1, 0);
        step();
        ch_en = 3'b111;
        wait_change(1, "ch1_clamp_rise", 1);
`ifdef CLKDIV_TICK_EN
        check("ch1_tick_high", 32'(tick[1]), 1);
`endif
        wait_change(1, "ch1_clamp_fall", 1);
`ifdef CLKDIV_TICK_EN
        check("ch1_tick_low", 32'(tick[1]), 0);
`endif

        // Out-of-range channel index.
        cfg_write(3, 9);
        check("oob_write_no_pend", 32'(pend), 0);

        // Mid-operation reset discards pending values.
        cfg_write(2, 9);
        check("ch2_pend_before_rst", 32'(pend[2]), 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_clk_out", 32'(clk_out), 0);
        check("rst_pend", 32'(pend), 0);
        wait_change(0, "ch0_restart_rise", 25);
        wait_change(2, "ch2_restart_default", 25);

        repeat (3) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clkdiv_multi.md
Name: clkdiv_multi

Overview:
Multi-channel programmable clock divider: the parametrised successor of the fixed single-output 1 MHz divider. It generates NUM_CH independent square-wave enables from the system clock (50 MHz on board). Each channel has a half-period that can be changed at runtime; new values take effect glitch-free at the channel's next toggle. Drives sensor-timing logic (DHT11 µs timebase, ms timeouts, LED/UART rates) from one block.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
CNT_W, 16, width of half-period value and per-channel counter
RST_HALF, 25, half-period loaded into every channel at reset (50 MHz / 50 = 1 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
ch_en  in  NUM_CH  per-channel run enable
cfg_we  in  1  one-cycle write strobe for a half-period value
cfg_ch  in  CH_W  target channel index; CH_W = max(1, clog2(NUM_CH))
cfg_half  in  CNT_W  new half-period in clk cycles
clk_out  out  NUM_CH  divided square wave per channel, registered
pend  out  NUM_CH  a written value is waiting to be applied on this channel
tick  out  NUM_CH  only with CLKDIV_TICK_EN; one-cycle pulse on each clk_out rising toggle

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: clk_out=0, pend=0, tick=0, every counter=0, half_cur=half_pend=RST_HALF. Reset asserted mid-operation discards pending writes and restarts all phases.
- Per-channel state: cnt, half_cur, half_pend, pend_valid (drives pend), out (drives clk_out).
- Running (ch_en[i]=1 sampled at the edge): if cnt == half_cur-1, then out toggles, cnt goes to 0, and if pend_valid then half_cur<=half_pend and pend_valid<=0. Otherwise cnt<=cnt+1.
- Output period is 2*half_cur cycles with 50% duty. After enable, clk_out rises on the half_cur-th edge with ch_en sampled high.
- Disabled (ch_en[i]=0): cnt<=0 and out<=0 on the next edge. Any pending value is applied immediately (half_cur<=half_pend, pend_valid<=0).
- Config write: on cfg_we=1 with cfg_ch<NUM_CH, set half_pend[cfg_ch]<=max(cfg_half,1) and pend_valid<=1. cfg_half=0 is clamped to 1, giving clk/2.
- cfg_ch>=NUM_CH: the write is ignored and no state changes.
- Multiple writes before a wrap: last value wins.
- Write in the same cycle as that channel's wrap: the wrap uses the previously pending state. The new value becomes pending, pend reads 1, and it is applied at the following wrap.
- Write in the same cycle as disable: the value is pending after the edge and is applied on the next disabled cycle.
- No combinational path from inputs to outputs. All outputs are registers.
- Counter never exceeds half_cur-1. Width is CNT_W with no overflow path.

Optional Feature:
CLKDIV_TICK_EN
- Defined: tick port present. tick[i]=1 for exactly one cycle, the cycle in which clk_out[i] is first high after a 0->1 toggle. Used as a clock-enable by downstream logic. Reset value 0. Held 0 while disabled.
- Undefined: tick port and its registers are absent. All other behaviour is identical.

Decomposition:
- Package clkdiv_pkg: CNT_W default, RST_HALF default, CH_W computation function, and the per-channel state struct/record layout.
- Sub-module clkdiv_chan: one channel, containing the counter, half_cur/half_pend, pending logic, out and tick. The top-level clkdiv_multi decodes cfg_ch into per-channel write enables and instantiates NUM_CH copies in a generate loop.

Test Plan:
- Reset, then ch_en=4'b0001 with default 25 -> clk_out[0] rises 25 cycles after enable, period 50, duty 25/25. Other channels stay 0.
- ch0 running at 25; write cfg_ch=0, cfg_half=3 at count 10 -> pend[0]=1 until the current half ends at cycle 25, then toggles every 3 cycles and pend[0]=0.
- ch2 running; drop ch_en[2] mid-count -> clk_out[2]=0 next cycle. Write half=5 -> pend[2] clears one cycle later. Re-enable -> first rise after 5 cycles, period 10.
- cfg_half=0 on ch1 -> clamped to 1: clk_out[1] toggles every cycle. With CLKDIV_TICK_EN, tick[1] pulses every 2 cycles.
- NUM_CH=3, cfg_ch=3 write -> no channel changes and pend stays 0. Write on ch0's exact wrap cycle -> old half used for one more half-period, new value applied at the next wrap.
- rst asserted for 1 cycle mid-operation with pend set -> all outputs 0, pending discarded, channels restart at half=25.
